// File: rtl/mode_select.sv
// rtl/mode_select.sv - pushbutton synchroniser, debouncer and 2-bit mode counter
module mode_select #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic       clear,
  output logic [1:0] sel,
  output logic       level,
  output logic       pressed
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     level_q, level_d;
  logic                     pressed_q, pressed_d;
  logic [1:0]               sel_q, sel_d;
  logic                     sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], button};
    cnt_d     = cnt_q;
    level_d   = level_q;
    pressed_d = 1'b0;
    sel_d     = sel_q;

    // Any sample matching the current level restarts the stability window.
    if (sync_bit == level_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d     = '0;
      level_d   = sync_bit;
      pressed_d = sync_bit;
    end

    if (clear) begin
      sel_d = 2'b00;
    end else if (pressed_d) begin
      sel_d = sel_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pressed_q <= 1'b0;
      sel_q     <= 2'b00;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      sel_q     <= sel_d;
    end
  end

  assign sel     = sel_q;
  assign level   = level_q;
  assign pressed = pressed_q;

endmodule
